muldiv_sequencer: RTL and testbench

- Iterative RV32M multiply/divide unit, sequenced by its own FSM. Sits beside the ALU in the EX stage.
- Accepts one M-extension op (funct7 = 0000001, op = 0110011) from the EX stage and raises Busy so the hazard logic stalls IF/ID/EX.
- Returns a registered Result with a one-cycle Done pulse; the EX/MEM register captures Result in that cycle.

---
 rtl/muldiv_sequencer_if.sv | 14 +
 rtl/muldiv_sequencer.sv | 153 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// EX-stage <-> iterative mul/div unit handshake: issue side (master) and unit side (slave).
interface muldiv_sequencer_if #(parameter int XLEN = 32);
  logic            Start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            Flush;
  logic            Busy;
  logic            Done;
  logic [XLEN-1:0] Result;

  modport master (output Start, funct3, SrcA, SrcB, Flush, input Busy, Done, Result);
  modport slave  (input Start, funct3, SrcA, SrcB, Flush, output Busy, Done, Result);
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide on magnitudes,
// sign fix-up in a final SIGN cycle. Divide-by-zero and signed overflow finish in one edge.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  muldiv_sequencer_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        op;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              neg;
  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]     rem;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   result;
  logic              busy, done;

  // ---- issue-side decode ----
  logic            a_sgn, b_sgn, a_neg, b_neg, neg_in;
  logic [XLEN-1:0] a_abs, b_abs, sp_res;
  logic            accept, is_div, div0, ovf, special;

  always_comb begin
    a_sgn  = 1'b0;
    b_sgn  = 1'b0;
    case (bus.funct3)
      3'd0, 3'd1, 3'd4, 3'd6: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      3'd2:                   a_sgn = 1'b1;
      default: ;
    endcase
    a_neg  = a_sgn & bus.SrcA[XLEN-1];
    b_neg  = b_sgn & bus.SrcB[XLEN-1];
    a_abs  = a_neg ? -bus.SrcA : bus.SrcA;
    b_abs  = b_neg ? -bus.SrcB : bus.SrcB;
    case (bus.funct3)
      3'd0, 3'd1, 3'd4: neg_in = a_neg ^ b_neg;
      3'd2, 3'd6:       neg_in = a_neg;
      default:          neg_in = 1'b0;
    endcase
    is_div  = bus.funct3[2];
    div0    = is_div && (bus.SrcB == '0);
    ovf     = is_div && !bus.funct3[0] && (bus.SrcA == {1'b1, {(XLEN-1){1'b0}}}) &&
              (bus.SrcB == '1);
    special = div0 | ovf;
    // rem* returns the dividend on /0; on overflow div returns SrcA (= most negative) and rem 0
    if (div0)           sp_res = bus.funct3[1] ? bus.SrcA : '1;
    else                sp_res = bus.funct3[1] ? '0 : bus.SrcA;
    accept = (state == IDLE) && bus.Start && !bus.Flush;
  end

  // ---- FSM ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (accept) begin
        busy      = 1'b1;
        state_nxt = special ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (bus.Flush)        state_nxt = IDLE;
        else if (cnt == LAST) state_nxt = SIGN;
      end
      SIGN: begin
        busy      = 1'b1;
        state_nxt = bus.Flush ? IDLE : DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- iteration step and sign fix-up ----
  logic [XLEN:0]     sum, shifted, diff;
  logic [2*XLEN-1:0] mul_nxt, prod;
  logic [XLEN-1:0]   quo, rmd, res;

  always_comb begin
    sum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, a_mag};
    mul_nxt = acc[0] ? {sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
    // rem < divisor is invariant, so diff[XLEN] is a clean borrow flag
    shifted = {rem[XLEN-1:0], acc[XLEN-1]};
    diff    = shifted - {1'b0, b_mag};
    prod    = neg ? -acc : acc;
    quo     = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rmd     = neg ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    case (op)
      3'd0:             res = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: res = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       res = quo;
      default:          res = rmd;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op     <= '0;
      a_mag  <= '0;
      b_mag  <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      rem    <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op    <= bus.funct3;
          a_mag <= a_abs;
          b_mag <= b_abs;
          neg   <= neg_in;
          cnt   <= '0;
          rem   <= '0;
          // divide shifts the dividend out of acc's low half while quotient bits shift in
          acc   <= {{XLEN{1'b0}}, is_div ? a_abs : b_abs};
          if (special) result <= sp_res;
        end
        CALC: if (!bus.Flush) begin
          cnt <= cnt + 1'b1;
          if (op[2]) begin
            rem             <= diff[XLEN] ? shifted : diff;
            acc[XLEN-1:0]   <= {acc[XLEN-2:0], ~diff[XLEN]};
          end else begin
            acc <= mul_nxt;
          end
        end
        SIGN: if (!bus.Flush) result <= res;
        default: ;
      endcase
    end
  end

  assign bus.Busy   = busy;
  assign bus.Done   = done;
  assign bus.Result = result;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized + directed bench for muldiv_sequencer against a plain-arithmetic RV32M model.
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] last_res = '0;

  muldiv_sequencer_if #(.XLEN(32)) bus ();
  muldiv_sequencer #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ov;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ov ? a : 32'(signed'(a) / signed'(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ov ? 32'h0 : 32'(signed'(a) % signed'(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0)) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Drive an op for one cycle; returns just after the accept edge with operands scrambled.
  task automatic issue(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    bus.Start  = 1'b1;
    bus.funct3 = f;
    bus.SrcA   = a;
    bus.SrcB   = b;
    #1 chk({tag, ".busy_issue"}, 64'(bus.Busy), 64'd1);
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    bus.SrcA  = $urandom;
    bus.SrcB  = $urandom;
  endtask

  // Count edges since accept until Done; lat0 = edges already elapsed.
  task automatic wait_done(input int lat0, output int lat, output bit busy_ok);
    lat = lat0;
    busy_ok = 1'b1;
    while (!bus.Done && lat < 100) begin
      if (!bus.Busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b);
    int lat;
    bit busy_ok;
    logic [31:0] exp;
    exp = ref_md(f, a, b);
    issue(tag, f, a, b);
    wait_done(1, lat, busy_ok);
    chk({tag, ".lat"}, 64'(lat), 64'(ref_lat(f, a, b)));
    chk({tag, ".result"}, 64'(bus.Result), 64'(exp));
    chk({tag, ".busy_in_done"}, 64'(bus.Busy), 64'd0);
    if (ref_lat(f, a, b) == 34) chk({tag, ".busy_calc"}, 64'(busy_ok), 64'd1);
    @(posedge clk);
    #1;
    chk({tag, ".done_pulse"}, 64'(bus.Done), 64'd0);
    chk({tag, ".hold"}, 64'(bus.Result), 64'(exp));
    last_res = exp;
  endtask

  initial begin
    int lat;
    bit busy_ok, saw;
    logic [2:0] f;
    logic [31:0] a, b;
    bus.Start = 1'b0; bus.funct3 = '0; bus.SrcA = '0; bus.SrcB = '0; bus.Flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 64'(bus.Busy), 64'd0);
    chk("rst.done", 64'(bus.Done), 64'd0);
    chk("rst.result", 64'(bus.Result), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD);
    run_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2);
    run_op("divu",   3'd5, 32'hFFFF_FFF9,  32'd2);
    run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2);
    run_op("remu",   3'd7, 32'hFFFF_FFF9,  32'd2);
    run_op("divu0",  3'd5, 32'd5,          32'd0);
    run_op("remu0",  3'd7, 32'd5,          32'd0);
    run_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF);
    run_op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 100);
        default: ;
      endcase
      run_op($sformatf("rnd%0d_f%0d", i, f), f, a, b);
    end

    // Start together with Flush is not accepted
    @(negedge clk);
    bus.Start = 1'b1; bus.Flush = 1'b1; bus.funct3 = 3'd0; bus.SrcA = 32'd3; bus.SrcB = 32'd4;
    #1 chk("startflush.busy", 64'(bus.Busy), 64'd0);
    @(posedge clk);
    #1;
    bus.Start = 1'b0; bus.Flush = 1'b0;
    chk("startflush.idle", 64'(bus.Busy), 64'd0);

    // Flush on the 10th CALC cycle kills the op
    issue("flush", 3'd0, 32'd3, 32'd4);
    repeat (9) begin @(posedge clk); #1; end
    bus.Flush = 1'b1;
    @(posedge clk);
    #1;
    bus.Flush = 1'b0;
    chk("flush.idle", 64'(bus.Busy), 64'd0);
    saw = 1'b0;
    repeat (40) begin
      if (bus.Done) saw = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("flush.no_done", 64'(saw), 64'd0);
    chk("flush.result_kept", 64'(bus.Result), 64'(last_res));

    // A second Start during CALC is ignored
    issue("ignore", 3'd0, 32'd3, 32'd4);
    repeat (4) begin @(posedge clk); #1; end
    bus.Start = 1'b1; bus.funct3 = 3'd5; bus.SrcA = 32'd100; bus.SrcB = 32'd0;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    wait_done(6, lat, busy_ok);
    chk("ignore.lat", 64'(lat), 64'd34);
    chk("ignore.result", 64'(bus.Result), 64'd12);
    chk("ignore.busy_calc", 64'(busy_ok), 64'd1);
    @(posedge clk);
    #1;
    chk("ignore.single", 64'(bus.Done), 64'd0);

    // Reset during CALC
    issue("rstmid", 3'd5, 32'd1000, 32'd3);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    chk("rstmid.busy", 64'(bus.Busy), 64'd0);
    chk("rstmid.done", 64'(bus.Done), 64'd0);
    chk("rstmid.result", 64'(bus.Result), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    last_res = '0;
    run_op("post_rst_divu", 3'd5, 32'd100, 32'd7);
    chk("post_rst_divu.14", 64'(bus.Result), 64'd14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
